prog_uart_streamer: RTL and testbench
=====================================

# prog_uart_streamer

Synthesizable, parametrised successor to the simulation-only program loader on the user-project IO. The block streams a program image from a synchronous ROM/SRAM read port out as 8N1/8N2 UART frames on a single serial pin, starting on the rising edge of a ready input (for example `mprj_io[37]`). It supports configurable word width, memory depth, baud divisor, stop bits and inter-byte gap, and can append an optional checksum byte. It sits in the user project, driving the serial receive input of the core's boot loader.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit; minimum 2.
- `WORD_W`, 32: memory word width; must be a multiple of 8.
- `DEPTH`, 1024: words addressable; `AW = $clog2(DEPTH)`.
- `STOP_BITS`, 1: 1 or 2.
- `GAP_BITS`, 0: idle bit-times inserted after every frame (0–15).

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  level input; a rising edge launches a transfer
- `word_count`  in  AW+1  words to send; sampled on the launch edge
- `mem_addr`  out  AW  read address to synchronous memory
- `mem_rdata`  in  WORD_W  read data, valid one cycle after `mem_addr`
- `tx`  out  1  serial output; idles high
- `busy`  out  1  high from the launch through the final stop/gap bit
- `done`  out  1  one-cycle pulse at the end of a transfer

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `mem_addr`=0; FSM in IDLE; `start_q`=0; checksum=0.
- Launch: in IDLE, `start` high while registered `start_q` low. While busy, `start` edges are ignored. A `start` held high does not relaunch.
- FSM states and transitions:
  - IDLE → FETCH on launch: latch `word_count`, set `mem_addr`=0, clear the checksum, set `busy`.
  - FETCH → LOAD: wait one cycle for memory latency.
  - LOAD: capture `mem_rdata` into the shift word and set byte index = 0. → START.
  - START: drive `tx`=0 for one bit time. → DATA.
  - DATA: send 8 bits, LSB first. Byte k is `word[8k+7:8k]`, so byte 0 goes out first. → STOP.
  - STOP: drive `tx`=1 for STOP_BITS bit times. → GAP, or skip GAP when GAP_BITS=0.
  - GAP: hold `tx`=1 for GAP_BITS bit times.
  - After the frame, one of:
    - More bytes remain in the word: → START with the next byte.
    - Last byte and more words remain: `mem_addr`+1 → FETCH.
    - Otherwise: → CSUM if enabled, else → DONE.
  - DONE: `done`=1 for one cycle, `busy`=0. → IDLE.
- `word_count`=0: IDLE → DONE directly. No frames are sent, and the checksum frame is not sent either.
- `word_count` > DEPTH: clamp to DEPTH. `mem_addr` never wraps.
- Bit timer: down-counter loaded with CLKS_PER_BIT−1 at each bit start. The bit ends when the timer reaches 0.
- Reset asserted mid-frame: `tx` goes high immediately (async), and the block returns to IDLE. A truncated frame is acceptable.

## Timing
- Let launch edge = E. FETCH is at E+1, LOAD at E+2, and `tx` falls at E+3 (registered output).
- Frame length = (9+STOP_BITS+GAP_BITS)·CLKS_PER_BIT cycles.
- Back-to-back bytes within a word: no extra cycles between frames.
- Word boundary: exactly 2 extra idle-high cycles (FETCH, LOAD) before the next start bit.
- `done` is asserted on the cycle after the last stop/gap bit ends. `busy` falls on the same edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `PROG_UART_CHECKSUM_EN` defined: after the last word, the block sends one extra frame containing the two's complement of the mod-256 sum of all transmitted bytes. Receiver sum including this byte = 0x00. The extra frame uses normal START/DATA/STOP/GAP timing with no fetch gap.
- Undefined: the CSUM state and the 8-bit accumulator are not built. The transfer ends after the last word.

## Structure
- Package `prog_uart_pkg`:
  - FSM state enum (IDLE, FETCH, LOAD, START, DATA, STOP, GAP, CSUM, DONE).
  - Constant `UART_DATA_BITS`=8.
  - Function `bytes_per_word(WORD_W)`.
- One sub-module, `uart_bit_timer`: loadable down-counter producing a `bit_tick`, parametrised by CLKS_PER_BIT.

## Test plan
- Single-word transfer:
  - Setup: CLKS_PER_BIT=4, STOP_BITS=1, GAP_BITS=0, mem[0]=0x44332211, `word_count`=1.
  - Response: bench UART decoder sees 0x11, 0x22, 0x33, 0x44. First `tx` fall at E+3. `done` at E+3+160.
- Multi-word with stop bits and gap:
  - Setup: `word_count`=3, STOP_BITS=2, GAP_BITS=1.
  - Response: 12 bytes in address order. Frame = 48 cycles. Exactly 2 extra idle cycles at each of the 2 word boundaries.
- Zero count and relaunch:
  - `word_count`=0 → `done` pulse with `tx` constantly high.
  - A second `start` pulse during busy → no relaunch, byte count unchanged.
- Checksum (with `PROG_UART_CHECKSUM_EN`):
  - Setup: mem[0]=0x44332211.
  - Response: 5th byte = 0x100−0xAA = 0x56.
- Mid-transfer reset:
  - Stimulus: assert `reset` during DATA of byte 2.
  - Response: `tx`=1, `busy`=0 and `mem_addr`=0 immediately. After release, a new launch restarts from address 0.
- Clamp:
  - Setup: DEPTH=4, `word_count`=7.
  - Response: exactly 16 bytes sent; `mem_addr` max = 3.

Source files
------------

// File: rtl/prog_uart_pkg.sv
// Shared types and helpers for the program-image UART streamer.
package prog_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP,
        GAP,
        CSUM,
        DONE
    } state_t;

    function automatic int bytes_per_word(input int word_w);
        return word_w / UART_DATA_BITS;
    endfunction

endpackage

// File: rtl/prog_uart_streamer_if.sv
// Streamer bus: launch control, synchronous memory read port, serial and status outputs.
interface prog_uart_streamer_if #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic              start;
    logic [AW:0]       word_count;
    logic [AW-1:0]     mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        input  start, word_count, mem_rdata,
        output mem_addr, tx, busy, done
    );

    modport slave (
        output start, word_count, mem_rdata,
        input  mem_addr, tx, busy, done
    );

endinterface

// File: rtl/prog_uart_streamer_bit_timer.sv
// Bit-period down-counter: reloads while held in load, ticks once per CLKS_PER_BIT cycles otherwise.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic bit_tick
);
    localparam int            CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= RELOAD;
        end else if (load || count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign bit_tick = !load && (count == '0);

endmodule

// File: rtl/prog_uart_streamer.sv
// Streams words from a synchronous memory as 8N1/8N2 UART frames, byte 0 of each word first.
// Define PROG_UART_CHECKSUM_EN to append a two's-complement checksum frame.
module prog_uart_streamer
    import prog_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0
) (
    input logic                  clock,
    input logic                  reset,
    prog_uart_streamer_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          BPW     = bytes_per_word(WORD_W);
    localparam int          BI_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t            state, state_next, frame_next;
    logic              start_q, launch, bit_tick, timer_load, frame_end;
    logic [AW:0]       words_left;
    logic [AW-1:0]     addr_q;
    logic [WORD_W-1:0] shift;
    logic [BI_W-1:0]   byte_idx;
    logic [$clog2(UART_DATA_BITS)-1:0] bit_idx;
    logic              stop_cnt;
    logic [3:0]        gap_cnt;
    logic              bit_last, stop_last, gap_last, byte_last, more_words;
    logic              csum_phase;
    logic [7:0]        csum_byte;
    logic              tx_d, busy_d, done_d, tx_q, busy_q, done_q;

    assign launch     = (state == IDLE) && bus.start && !start_q;
    assign timer_load = !(state inside {START, DATA, STOP, GAP, CSUM});
    assign bit_last   = (int'(bit_idx) == UART_DATA_BITS - 1);
    assign stop_last  = (int'(stop_cnt) == STOP_BITS - 1);
    assign gap_last   = (int'(gap_cnt) == GAP_BITS - 1);
    assign byte_last  = (int'(byte_idx) == BPW - 1);
    assign more_words = (words_left > (AW + 1)'(1));
    assign frame_end  = bit_tick && ((state == STOP && stop_last && GAP_BITS == 0) ||
                                     (state == GAP && gap_last));

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .bit_tick (bit_tick)
    );

`ifdef PROG_UART_CHECKSUM_EN
    localparam state_t LAST_WORD_NEXT = CSUM;
    logic [7:0] csum;

    // Each byte is summed as its start bit completes; the checksum frame itself is excluded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            csum       <= '0;
            csum_phase <= 1'b0;
        end else begin
            if (launch) begin
                csum       <= '0;
                csum_phase <= 1'b0;
            end
            if (state == START && bit_tick) csum <= csum + shift[7:0];
            if (frame_end && frame_next == CSUM) csum_phase <= 1'b1;
        end
    end

    assign csum_byte = 8'(~csum + 8'd1);
`else
    localparam state_t LAST_WORD_NEXT = DONE;
    assign csum_phase = 1'b0;
    assign csum_byte  = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        if (csum_phase)      frame_next = DONE;
        else if (!byte_last) frame_next = START;
        else if (more_words) frame_next = FETCH;
        else                 frame_next = LAST_WORD_NEXT;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (launch) state_next = (bus.word_count == '0) ? DONE : FETCH;
            FETCH:       state_next = LOAD;
            LOAD:        state_next = START;
            START, CSUM: if (bit_tick) state_next = DATA;
            DATA:        if (bit_tick && bit_last) state_next = STOP;
            STOP:        if (bit_tick && stop_last) state_next = (GAP_BITS == 0) ? frame_next : GAP;
            GAP:         if (bit_tick && gap_last) state_next = frame_next;
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            START, CSUM: tx_d = 1'b0;
            DATA:        tx_d = shift[0];
            default:     tx_d = 1'b1;
        endcase
        busy_d = !(state == IDLE || state == DONE);
        done_d = (state == DONE);
    end

    // Shift register walks bytes LSB-first; after eight shifts the next byte sits at [7:0].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b0;
            words_left <= '0;
            addr_q     <= '0;
            shift      <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            start_q <= bus.start;
            if (launch) begin
                words_left <= (bus.word_count > DEPTH_W) ? DEPTH_W : bus.word_count;
                addr_q     <= '0;
            end
            if (state == LOAD) begin
                shift    <= bus.mem_rdata;
                byte_idx <= '0;
            end
            if (state == DATA && bit_tick) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == STOP && bit_tick) stop_cnt <= stop_last ? 1'b0 : ~stop_cnt;
            if (state == GAP && bit_tick)  gap_cnt  <= gap_last ? '0 : gap_cnt + 1'b1;
            if (frame_end) begin
                if (frame_next == START) byte_idx <= byte_idx + 1'b1;
                if (frame_next == FETCH) begin
                    addr_q     <= addr_q + 1'b1;
                    words_left <= words_left - 1'b1;
                end
                if (frame_next == CSUM) shift <= WORD_W'(csum_byte);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_addr = addr_q;

endmodule

// File: tb/tb_prog_uart_streamer.sv
// Directed bench for prog_uart_streamer: two DUT configurations, a UART decoder per DUT.
module tb_prog_uart_streamer;
    localparam int CLKS    = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME_A = 10 * CLKS;
    localparam int FRAME_B = 12 * CLKS;
`ifdef PROG_UART_CHECKSUM_EN
    localparam int CSUM_FRAMES = 1;
`else
    localparam int CSUM_FRAMES = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    logic [7:0]  exp_all [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                  8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
    logic [7:0]  a_bytes[$], b_bytes[$];
    int          a_falls[$], b_falls[$];
    int          a_ferr = 0, b_ferr = 0;

    prog_uart_streamer_if #(.WORD_W(32), .DEPTH(DEPTH)) a_if ();
    prog_uart_streamer_if #(.WORD_W(32), .DEPTH(DEPTH)) b_if ();

    prog_uart_streamer #(.CLKS_PER_BIT(CLKS), .WORD_W(32), .DEPTH(DEPTH),
                         .STOP_BITS(1), .GAP_BITS(0)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a_if)
    );

    prog_uart_streamer #(.CLKS_PER_BIT(CLKS), .WORD_W(32), .DEPTH(DEPTH),
                         .STOP_BITS(2), .GAP_BITS(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) a_if.mem_rdata <= mem_a[a_if.mem_addr];
    always @(posedge clock) b_if.mem_rdata <= mem_b[b_if.mem_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decodes one frame, sampling mid-bit on falling clock edges.
    task automatic uart_rx(input bit sel, output logic [7:0] data, output bit ok, output int t0);
        do @(negedge clock); while (reset || (sel ? b_if.tx : a_if.tx) !== 1'b0);
        t0 = cyc;
        repeat (CLKS / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            repeat (CLKS) @(negedge clock);
            data[i] = sel ? b_if.tx : a_if.tx;
        end
        repeat (CLKS) @(negedge clock);
        ok = ((sel ? b_if.tx : a_if.tx) == 1'b1);
    endtask

    initial begin : mon_a
        logic [7:0] d;
        bit         ok;
        int         t;
        forever begin
            uart_rx(1'b0, d, ok, t);
            a_bytes.push_back(d);
            a_falls.push_back(t);
            if (!ok) a_ferr++;
        end
    end

    initial begin : mon_b
        logic [7:0] d;
        bit         ok;
        int         t;
        forever begin
            uart_rx(1'b1, d, ok, t);
            b_bytes.push_back(d);
            b_falls.push_back(t);
            if (!ok) b_ferr++;
        end
    end

    task automatic launch(input bit sel, input int wc, output int e);
        @(negedge clock);
        if (sel) begin
            b_if.word_count = 3'(wc);
            b_if.start      = 1'b1;
        end else begin
            a_if.word_count = 3'(wc);
            a_if.start      = 1'b1;
        end
        @(negedge clock);
        e = cyc;
    endtask

    task automatic wait_done(input bit sel, input int limit, output int at, output int max_addr);
        at       = -1;
        max_addr = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (int'(sel ? b_if.mem_addr : a_if.mem_addr) > max_addr)
                max_addr = int'(sel ? b_if.mem_addr : a_if.mem_addr);
            if (sel ? b_if.done : a_if.done) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_stream(input string tag, input bit sel, input int base, input int n,
                                input logic [7:0] csum);
        int         got_n;
        logic [7:0] g;
        got_n = (sel ? b_bytes.size() : a_bytes.size()) - base;
        check({tag, "_count"}, got_n, n + CSUM_FRAMES);
        for (int i = 0; i < n + CSUM_FRAMES && i < got_n; i++) begin
            g = sel ? b_bytes[base + i] : a_bytes[base + i];
            check($sformatf("%s_byte%0d", tag, i), g, (i < n) ? exp_all[i] : csum);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int e, at, mx, base, ferr0, got_n;
        bit tx_low;

        a_if.start = 1'b0;  a_if.word_count = '0;
        b_if.start = 1'b0;  b_if.word_count = '0;
        mem_a = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
        mem_b = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};

        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_tx",   a_if.tx,       1'b1);
        check("rst_busy", a_if.busy,     1'b0);
        check("rst_done", a_if.done,     1'b0);
        check("rst_addr", a_if.mem_addr, 2'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Single word, 8N1: 4 frames of 40 cycles after a 3-cycle lead-in.
        base = a_bytes.size();
        ferr0 = a_ferr;
        launch(1'b0, 1, e);
        @(negedge clock);
        check("t1_busy_high", a_if.busy, 1'b1);
        wait_done(1'b0, 500, at, mx);
        check("t1_done_time", at, e + 3 + (4 + CSUM_FRAMES) * FRAME_A);
        check("t1_busy_at_done", a_if.busy, 1'b0);
        check("t1_first_fall", (a_falls.size() > base) ? a_falls[base] : -1, e + 3);
        check_stream("t1", 1'b0, base, 4, 8'h56);
        check("t1_framing", a_ferr - ferr0, 0);
        @(negedge clock);
        check("t1_done_pulse", a_if.done, 1'b0);
        a_if.start = 1'b0;
        repeat (3) @(negedge clock);

        // Three words, 8N2 plus one gap bit: 48-cycle frames, 2 extra cycles per word boundary.
        base = b_bytes.size();
        ferr0 = b_ferr;
        launch(1'b1, 3, e);
        wait_done(1'b1, 1500, at, mx);
        check("t2_done_time", at, e + 3 + (12 + CSUM_FRAMES) * FRAME_B + 4);
        check_stream("t2", 1'b1, base, 12, 8'hD2);
        check("t2_framing", b_ferr - ferr0, 0);
        got_n = b_falls.size() - base;
        for (int i = 1; i < 12 + CSUM_FRAMES && i < got_n; i++)
            check($sformatf("t2_spacing%0d", i), b_falls[base + i] - b_falls[base + i - 1],
                  (i % 4 == 0 && i < 12) ? FRAME_B + 2 : FRAME_B);
        b_if.start = 1'b0;
        repeat (3) @(negedge clock);

        // Start edge while busy, then held high past done: neither relaunches.
        base = a_bytes.size();
        launch(1'b0, 1, e);
        repeat (10) @(negedge clock);
        a_if.start = 1'b0;
        @(negedge clock);
        a_if.start = 1'b1;
        wait_done(1'b0, 500, at, mx);
        check("t3_done_time", at, e + 3 + (4 + CSUM_FRAMES) * FRAME_A);
        repeat (80) @(negedge clock);
        check("t3_no_relaunch_busy", a_if.busy, 1'b0);
        check("t3_byte_count", a_bytes.size() - base, 4 + CSUM_FRAMES);
        a_if.start = 1'b0;
        repeat (3) @(negedge clock);

        // Zero word count: immediate done, line stays idle.
        base = a_bytes.size();
        launch(1'b0, 0, e);
        at = -1;
        tx_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (a_if.tx !== 1'b1) tx_low = 1'b1;
            if (a_if.done && at < 0) at = cyc;
        end
        check("t4_done_time", at, e + 1);
        check("t4_tx_low", tx_low, 1'b0);
        check("t4_byte_count", a_bytes.size() - base, 0);
        a_if.start = 1'b0;
        repeat (3) @(negedge clock);

        // Reset during DATA of the second byte of word 1, then relaunch from address 0.
        launch(1'b0, 2, e);
        while (cyc < e + 222) @(negedge clock);
        check("t5_busy_before", a_if.busy, 1'b1);
        check("t5_addr_before", a_if.mem_addr, 2'd1);
        reset = 1'b1;
        #1;
        check("t5_rst_tx",   a_if.tx,       1'b1);
        check("t5_rst_busy", a_if.busy,     1'b0);
        check("t5_rst_addr", a_if.mem_addr, 2'd0);
        a_if.start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        base = a_bytes.size();
        launch(1'b0, 1, e);
        wait_done(1'b0, 500, at, mx);
        check("t5_done_time", at, e + 3 + (4 + CSUM_FRAMES) * FRAME_A);
        check_stream("t5", 1'b0, base, 4, 8'h56);
        a_if.start = 1'b0;
        repeat (3) @(negedge clock);

        // word_count above DEPTH clamps to DEPTH words.
        base = a_bytes.size();
        launch(1'b0, 7, e);
        wait_done(1'b0, 2000, at, mx);
        check("t6_done_time", at, e + 3 + (16 + CSUM_FRAMES) * FRAME_A + 6);
        check("t6_max_addr", mx, 3);
        check_stream("t6", 1'b0, base, 16, 8'h08);
        a_if.start = 1'b0;
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
